// File: rtl/imem_pkg.sv
// Shared defaults and address-decode helpers for the instruction memory and the PC logic.
package imem_pkg;

  localparam int unsigned IMEM_DATA_W = 32;
  localparam int unsigned IMEM_DEPTH  = 64;

  localparam logic [IMEM_DATA_W-1:0] IMEM_NOP_WORD = '0;

  // Addresses are widened to 64 bits so one helper serves any bus width up to 64.
  function automatic logic [63:0] imem_word_index(input logic [63:0] addr,
                                                  input logic        byte_addr);
    return byte_addr ? (addr >> 2) : addr;
  endfunction

  // Misaligned byte addresses are reported exactly like out-of-range ones.
  function automatic logic imem_addr_ok(input logic [63:0] addr,
                                        input logic        byte_addr,
                                        input int unsigned depth);
    logic [63:0] idx;
    logic        misaligned;
    idx        = imem_word_index(addr, byte_addr);
    misaligned = byte_addr && (addr[1:0] != 2'b00);
    return !misaligned && (idx < 64'(depth));
  endfunction

endpackage

// File: rtl/imem_array.sv
// Single-port-write, synchronous-read program store with write-first bypass; no reset.
module imem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    // Read data only moves on an accepted fetch, so it holds through stalls.
    if (re) begin
      rdata_q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instruction_memory_sync.sv
// Clocked instruction memory for the fetch stage: load port, one-cycle registered read,
// stall/flush control, valid flag and out-of-range/misalignment detection.
module instruction_memory_sync
  import imem_pkg::*;
#(
  parameter int unsigned          DATA_W    = IMEM_DATA_W,
  parameter int unsigned          DEPTH     = IMEM_DEPTH,
  parameter int unsigned          ADDR_W    = 32,
  parameter bit                   BYTE_ADDR = 1'b1,
  parameter logic [DATA_W-1:0]    NOP_WORD  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] address,
  input  logic              stall,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] instruction,
  output logic              valid,
  output logic              addr_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [63:0]       rd_ext, wr_ext;
  logic              rd_ok, wr_ok;
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic              fetch_go, write_go;
  logic [DATA_W-1:0] arr_rdata;
  logic              valid_q, err_q;

  assign rd_ext = 64'(address);
  assign wr_ext = 64'(wr_addr);
  assign rd_ok  = imem_addr_ok(rd_ext, BYTE_ADDR, DEPTH);
  assign wr_ok  = imem_addr_ok(wr_ext, BYTE_ADDR, DEPTH);

  // Only the low index bits reach the array; the range check above guards the rest.
  if (BYTE_ADDR) begin : g_byte_idx
    assign rd_idx = address[IDX_W+1:2];
    assign wr_idx = wr_addr[IDX_W+1:2];
  end else begin : g_word_idx
    assign rd_idx = address[IDX_W-1:0];
    assign wr_idx = wr_addr[IDX_W-1:0];
  end

  assign fetch_go = rd_en && rd_ok && !stall && !flush;
  assign write_go = wr_en && wr_ok;

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (write_go),
    .waddr (wr_idx),
    .wdata (wr_data),
    .re    (fetch_go),
    .raddr (rd_idx),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (stall) begin
      valid_q <= valid_q;
      err_q   <= err_q;
    end else if (rd_en) begin
      valid_q <= rd_ok;
      err_q   <= !rd_ok;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end
  end

  // Output is gated by registered state only, so reset blanks it without waiting for an edge.
  assign instruction = valid_q ? arr_rdata : NOP_WORD;
  assign valid       = valid_q;
  assign addr_err    = err_q;

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Directed and randomized checks of instruction_memory_sync against an array-based model.
module tb_instruction_memory_sync;

  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, stall, flush, wr_en;
  logic [31:0] address, wr_addr, wr_data;
  logic [31:0] instruction;
  logic        valid, addr_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instruction_memory_sync #(
    .DATA_W    (32),
    .DEPTH     (DEPTH),
    .ADDR_W    (32),
    .BYTE_ADDR (1'b1),
    .NOP_WORD  (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .address     (address),
    .stall       (stall),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .instruction (instruction),
    .valid       (valid),
    .addr_err    (addr_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: word-addressed array plus expected output values.
  logic [31:0] mm    [DEPTH];
  bit          known [DEPTH];
  logic [31:0] m_instr = '0;
  bit          m_valid = 1'b0;
  bit          m_err   = 1'b0;
  bit          m_known = 1'b0;

  function automatic bit m_good(input logic [31:0] a);
    if (a % 4 != 0) return 1'b0;
    return (a / 4) < DEPTH;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_instr = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else begin
      if (wr_en && m_good(wr_addr)) begin
        mm[wr_addr / 4]    = wr_data;
        known[wr_addr / 4] = 1'b1;
      end
      if (flush) begin
        m_instr = '0; m_valid = 1'b0; m_err = 1'b0;
      end else if (stall) begin
        // outputs hold
      end else if (rd_en && m_good(address)) begin
        m_instr = mm[address / 4];
        m_known = known[address / 4];
        m_valid = 1'b1;
        m_err   = 1'b0;
      end else if (rd_en) begin
        m_instr = '0; m_valid = 1'b0; m_err = 1'b1;
      end else begin
        m_instr = '0; m_valid = 1'b0; m_err = 1'b0;
      end
      #1;
      chk("cmp_valid", 32'(valid), 32'(m_valid));
      chk("cmp_addr_err", 32'(addr_err), 32'(m_err));
      if (!m_valid || m_known) chk("cmp_instruction", instruction, m_instr);
    end
  end

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 7)       return 32'($urandom_range(0, DEPTH - 1) * 4);
    else if (sel == 7) return 32'($urandom_range(0, 255));
    else if (sel == 8) return 32'(256 + $urandom_range(0, 1000));
    else               return $urandom;
  endfunction

  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'h0022_0000;
    prog[1] = 32'h0062_0000;
    prog[2] = 32'h0064_0000;
    prog[3] = 32'h00A6_0000;
    rst = 1'b1; rd_en = 1'b0; stall = 1'b0; flush = 1'b0; wr_en = 1'b0;
    address = '0; wr_addr = '0; wr_data = '0;

    repeat (3) begin
      @(negedge clk);
      chk("reset_instruction", instruction, 32'h0);
      chk("reset_valid", 32'(valid), 32'h0);
      chk("reset_addr_err", 32'(addr_err), 32'h0);
    end
    rst = 1'b0;

    // Fill every word so the model knows all contents, then place the test program.
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = 32'(i * 4); wr_data = $urandom;
      if (i < 4)  wr_data = prog[i];
      if (i == 63) wr_data = 32'h3F3F_0063;
      @(negedge clk);
    end
    wr_en = 1'b0;

    // Back-to-back fetch of 0, 4, 8, 12.
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; address = 32'(i * 4);
      @(negedge clk);
      chk("fetch_data", instruction, prog[i]);
      chk("fetch_valid", 32'(valid), 32'h1);
    end
    rd_en = 1'b0;
    @(negedge clk);

    // Stall for two cycles on address 8, then flush together with stall.
    rd_en = 1'b1; address = 32'd0;
    @(negedge clk);
    address = 32'd4;
    @(negedge clk);
    address = 32'd8; stall = 1'b1;
    @(negedge clk);
    chk("stall1_data", instruction, 32'h0062_0000);
    chk("stall1_valid", 32'(valid), 32'h1);
    @(negedge clk);
    chk("stall2_data", instruction, 32'h0062_0000);
    chk("stall2_valid", 32'(valid), 32'h1);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_data", instruction, 32'h0);
    chk("flush_valid", 32'(valid), 32'h0);
    flush = 1'b0; stall = 1'b0; rd_en = 1'b0;
    @(negedge clk);

    // Range and alignment.
    rd_en = 1'b1; address = 32'd252;
    @(negedge clk);
    chk("range_last_data", instruction, 32'h3F3F_0063);
    chk("range_last_valid", 32'(valid), 32'h1);
    chk("range_last_err", 32'(addr_err), 32'h0);
    address = 32'd256;
    @(negedge clk);
    chk("range_256_data", instruction, 32'h0);
    chk("range_256_valid", 32'(valid), 32'h0);
    chk("range_256_err", 32'(addr_err), 32'h1);
    address = 32'hFFFF_FF00;
    @(negedge clk);
    chk("range_high_valid", 32'(valid), 32'h0);
    chk("range_high_err", 32'(addr_err), 32'h1);
    address = 32'd6;
    @(negedge clk);
    chk("misalign_data", instruction, 32'h0);
    chk("misalign_valid", 32'(valid), 32'h0);
    chk("misalign_err", 32'(addr_err), 32'h1);

    // Write-first collision.
    address = 32'd16; wr_en = 1'b1; wr_addr = 32'd16; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("collide_data", instruction, 32'hDEAD_BEEF);
    chk("collide_valid", 32'(valid), 32'h1);

    // Illegal write, then a write during stall.
    rd_en = 1'b0; wr_addr = 32'd256; wr_data = 32'h1234_5678;
    @(negedge clk);
    wr_addr = 32'd20; wr_data = 32'hCAFE_0001; stall = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; stall = 1'b0; rd_en = 1'b1; address = 32'd0;
    @(negedge clk);
    chk("no_alias_mem0", instruction, 32'h0022_0000);
    address = 32'd20;
    @(negedge clk);
    chk("stalled_write", instruction, 32'hCAFE_0001);

    // Asynchronous reset between edges.
    address = 32'd4;
    @(negedge clk);
    chk("pre_reset_valid", 32'(valid), 32'h1);
    rd_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_instruction", instruction, 32'h0);
    chk("async_rst_valid", 32'(valid), 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    rd_en = 1'b1; address = 32'd4;
    @(negedge clk);
    chk("retained_mem1", instruction, 32'h0062_0000);
    chk("retained_valid", 32'(valid), 32'h1);

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      rd_en   = ($urandom_range(0, 99) < 80);
      stall   = ($urandom_range(0, 9) == 0);
      flush   = ($urandom_range(0, 15) == 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      address = rand_addr();
      wr_addr = ($urandom_range(0, 7) == 0) ? address : rand_addr();
      wr_data = $urandom;
      @(negedge clk);
    end
    rd_en = 1'b0; stall = 1'b0; flush = 1'b0; wr_en = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
